// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: single-cycle multiply, 32-step restoring divide.
// Optional MULDIV_EARLY_OUT_EN: trivial divides (B==0, overflow, |B|>|A|) bypass the iteration loop.
module ex_muldiv_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DIV_CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t                 state;
  logic [1:0]             op;
  logic [XLEN-1:0]        opa, opb;
  logic [XLEN-1:0]        divisor, quot, rem;
  logic                   neg_q, neg_r, div_zero, div_ovf;
  logic [DIV_CNT_W-1:0]   cnt;

  logic                   in_signed, in_zero, in_ovf;
  logic [XLEN-1:0]        abs_a, abs_b;
  logic [2*XLEN-1:0]      mul_a, mul_b, prod;
  logic [XLEN:0]          rem_sh, rem_sub;
  logic                   q_bit;
  logic [XLEN-1:0]        rem_next, q_fix, r_fix;

  always_comb begin
    in_signed = ~funct3[0];
    abs_a     = (in_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    abs_b     = (in_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
    in_zero   = (rs2_data == '0);
    in_ovf    = in_signed && (rs1_data == MIN_INT) && (rs2_data == '1);
  end

  // Operands are explicitly extended to 64 bits so an unsigned multiply yields the exact signed/mixed product.
  always_comb begin
    mul_a = {{XLEN{(op != 2'b11) & opa[XLEN-1]}}, opa};
    mul_b = {{XLEN{~op[1] & opb[XLEN-1]}}, opb};
    prod  = mul_a * mul_b;
  end

  // Restoring step: the borrow out of the 33-bit subtract is the inverted quotient bit.
  always_comb begin
    rem_sh   = {rem, quot[XLEN-1]};
    rem_sub  = rem_sh - {1'b0, divisor};
    q_bit    = ~rem_sub[XLEN];
    rem_next = q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
  end

  always_comb begin
    q_fix = neg_q ? -quot : quot;
    r_fix = neg_r ? -rem : rem;
    if (div_zero) begin
      q_fix = '1;
      r_fix = opa;
    end else if (div_ovf) begin
      q_fix = MIN_INT;
      r_fix = '0;
    end
  end

  assign busy = (state == IDLE && start && !flush) || state == MUL || state == DIV || state == FIX;
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      op       <= '0;
      opa      <= '0;
      opb      <= '0;
      divisor  <= '0;
      quot     <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      cnt      <= '0;
    end else if (flush && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op  <= funct3[1:0];
            opa <= rs1_data;
            opb <= rs2_data;
            if (!funct3[2]) begin
              state <= MUL;
            end else begin
              divisor  <= abs_b;
              quot     <= abs_a;
              rem      <= '0;
              neg_q    <= in_signed & (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
              neg_r    <= in_signed & rs1_data[XLEN-1];
              div_zero <= in_zero;
              div_ovf  <= in_ovf;
              cnt      <= DIV_CNT_W'(XLEN-1);
`ifdef MULDIV_EARLY_OUT_EN
              // Presetting quotient 0 / remainder |A| makes FIX produce the same bits as the full loop.
              if (in_zero || in_ovf || abs_b > abs_a) begin
                quot  <= '0;
                rem   <= abs_a;
                state <= FIX;
              end else begin
                state <= DIV;
              end
`else
              state <= DIV;
`endif
            end
          end
        end
        MUL: begin
          result <= (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state  <= DONE;
        end
        DIV: begin
          quot <= {quot[XLEN-2:0], q_bit};
          rem  <= rem_next;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          result <= op[1] ? r_fix : q_fix;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
